// File: rtl/cast_flit_sequencer_pkg.sv
// Shared NoC package: multicast sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cast_flit_sequencer_pkg;

  typedef logic [1:0] seq_state_t;

  // Kept as plain constants so older blocks that compare raw state codes
  // keep working.
  localparam seq_state_t ST_IDLE = 2'd0;  // no flit held
  localparam seq_state_t ST_SEND = 2'd1;  // flit held, requesting the switch
  localparam seq_state_t ST_DROP = 2'd2;  // one-cycle discard of a bad flit

endpackage

// File: rtl/params.svh
// Shared router build parameters.
// PN: number of output ports reachable from one router input port.
// Kept as a macro so every block of the router port agrees on it.
`ifndef CAST_PARAMS_SVH
`define CAST_PARAMS_SVH
`define PN 5
`endif

// File: rtl/cast_flit_sequencer.sv
// Multicast flit sequencer: holds one flit and issues one switch request per
// destination supplied by the external roller, one copy per granted cycle.
// Latency: accepted flit requests the next cycle; each grant moves one copy
// the same cycle.
// Backpressure: in_ready only in IDLE or on the final granted copy; a missing
// grant stalls indefinitely with the request held.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   in_valid/in_flit/in_ready  upstream flit handshake
//   roll_req_port/roll_last    current destination and last flag from roller
//   roll_en                    advance pulse to the roller
//   out_req/out_grant          switch request and grant
//   out_valid/out_flit/out_last  copy transfer
//   err                        sticky error (zero destination or copy overrun)
`include "params.svh"

module cast_flit_sequencer
  import cast_flit_sequencer_pkg::*;
#(
  parameter int FLIT_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  input  logic [`PN-1:0]    roll_req_port,
  input  logic              roll_last,
  output logic              roll_en,
  output logic [`PN-1:0]    out_req,
  input  logic              out_grant,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_last,
  output logic              err
);

  localparam int CNT_W = $clog2(`PN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(`PN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(`PN);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [FLIT_W-1:0] hold_flit;
  logic [CNT_W-1:0]  copy_cnt;

  logic in_send;
  logic zero_dst;
  logic grant_ok;
  logic cap_hit;
  logic end_flit;
  logic overrun;
  logic hs;

  assign in_send  = (state == ST_SEND);
  // A roller with no destination left means a corrupt routing entry.
  assign zero_dst = in_send && (roll_req_port == '0);
  // Grant only counts while a real request is on the wire.
  assign grant_ok = in_send && !zero_dst && out_grant;
  // The PN-th copy is always the final one, whatever the roller says.
  assign cap_hit  = (copy_cnt == CNT_LAST);
  assign end_flit = grant_ok && (roll_last || cap_hit);
  assign overrun  = grant_ok && !roll_last && cap_hit;

  // Ready on the final copy lets the next flit in with no idle cycle.
  assign in_ready = (state == ST_IDLE) || end_flit;
  assign hs       = in_valid && in_ready;

  assign out_req   = in_send ? roll_req_port : '0;
  assign out_valid = grant_ok;
  assign roll_en   = grant_ok;
  assign out_last  = end_flit;
  assign out_flit  = grant_ok ? hold_flit : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = ST_SEND;
      ST_SEND: begin
        if (zero_dst)      state_nxt = ST_DROP;
        else if (end_flit) state_nxt = hs ? ST_SEND : ST_IDLE;
      end
      ST_DROP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      hold_flit <= '0;
      copy_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        hold_flit <= in_flit;
        copy_cnt  <= '0;
      end else if (grant_ok && (copy_cnt != CNT_MAX)) begin
        // Saturate rather than wrap so an overrun can never alias to copy 0.
        copy_cnt <= copy_cnt + 1'b1;
      end
      if (zero_dst || overrun) err <= 1'b1;
    end
  end

endmodule
